// File: rtl/cpu_clock_controller.sv
// rtl/cpu_clock_controller.sv - run/step/halt clock-enable generator for the FPGA CPU build
module cpu_clock_controller #(
  parameter int DIV_COUNT       = 100000,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 32
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             run_sw,
  input  logic             step_btn,
  input  logic             halt_req,
  output logic             cpu_ce,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] cycle_count
);

  localparam int DIV_W = $clog2(DIV_COUNT);
  localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV_COUNT - 1);
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_RUN    = 2'b01,
    S_STEP   = 2'b10,
    S_HALTED = 2'b11
  } state_t;

  logic             run_meta_q, run_meta_d;
  logic             run_s_q, run_s_d;
  logic             btn_meta_q, btn_meta_d;
  logic             btn_s_q, btn_s_d;
  logic             db_q, db_d;
  logic             db_prev_q, db_prev_d;
  logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  state_t           state_q, state_d;
  logic             cpu_ce_q, cpu_ce_d;
  logic [CNT_W-1:0] cycle_count_q, cycle_count_d;
  logic             step_req;
  logic             stay_run;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      run_meta_q    <= 1'b0;
      run_s_q       <= 1'b0;
      btn_meta_q    <= 1'b0;
      btn_s_q       <= 1'b0;
      db_q          <= 1'b0;
      db_prev_q     <= 1'b0;
      db_cnt_q      <= '0;
      div_cnt_q     <= '0;
      state_q       <= S_IDLE;
      cpu_ce_q      <= 1'b0;
      cycle_count_q <= '0;
    end else begin
      run_meta_q    <= run_meta_d;
      run_s_q       <= run_s_d;
      btn_meta_q    <= btn_meta_d;
      btn_s_q       <= btn_s_d;
      db_q          <= db_d;
      db_prev_q     <= db_prev_d;
      db_cnt_q      <= db_cnt_d;
      div_cnt_q     <= div_cnt_d;
      state_q       <= state_d;
      cpu_ce_q      <= cpu_ce_d;
      cycle_count_q <= cycle_count_d;
    end
  end

  // Synchronizers and debouncer; the run of mismatching samples restarts on any match.
  always_comb begin
    run_meta_d = run_sw;
    run_s_d    = run_meta_q;
    btn_meta_d = step_btn;
    btn_s_d    = btn_meta_q;
    db_d       = db_q;
    db_cnt_d   = '0;
    if (btn_s_q != db_q) begin
      if (db_cnt_q == DB_LAST) begin
        db_d = btn_s_q;
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end
    end
    db_prev_d = db_q;
    step_req  = db_q & ~db_prev_q;
  end

  always_comb begin
    state_d = state_q;
    if (state_q != S_HALTED && halt_req) begin
      state_d = S_HALTED;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (run_s_q)       state_d = S_RUN;
          else if (step_req) state_d = S_STEP;
        end
        S_RUN: begin
          if (!run_s_q) state_d = S_IDLE;
        end
        S_STEP: state_d = S_IDLE;
        S_HALTED: begin
          if (!run_s_q && !halt_req) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // A due RUN pulse is only issued if the FSM stays in RUN, so halt or run-off suppress it.
  always_comb begin
    stay_run  = (state_q == S_RUN) && (state_d == S_RUN);
    cpu_ce_d  = ((state_q == S_IDLE) && (state_d == S_STEP)) ||
                (stay_run && (div_cnt_q == DIV_LAST));
    div_cnt_d = '0;
    if (stay_run && (div_cnt_q != DIV_LAST)) begin
      div_cnt_d = div_cnt_q + DIV_W'(1);
    end
    cycle_count_d = cycle_count_q;
    if (cpu_ce_q && (cycle_count_q != {CNT_W{1'b1}})) begin
      cycle_count_d = cycle_count_q + CNT_W'(1);
    end
  end

  assign cpu_ce      = cpu_ce_q;
  assign state       = state_q;
  assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_cpu_clock_controller.sv
// tb/tb_cpu_clock_controller.sv - directed self-checking bench for cpu_clock_controller
module tb_cpu_clock_controller;

  localparam int DIV = 4;
  localparam int DEB = 3;
  localparam int CW  = 3;

  logic          clk_in = 1'b0;
  logic          rst_n = 1'b1;
  logic          run_sw = 1'b0;
  logic          step_btn = 1'b0;
  logic          halt_req = 1'b0;
  logic          cpu_ce;
  logic [1:0]    state;
  logic [CW-1:0] cycle_count;

  int n_checks = 0;
  int n_fail = 0;

  cpu_clock_controller #(
    .DIV_COUNT(DIV),
    .DEBOUNCE_CYCLES(DEB),
    .CNT_W(CW)
  ) dut (
    .clk_in(clk_in),
    .rst_n(rst_n),
    .run_sw(run_sw),
    .step_btn(step_btn),
    .halt_req(halt_req),
    .cpu_ce(cpu_ce),
    .state(state),
    .cycle_count(cycle_count)
  );

  always #5 clk_in = ~clk_in;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    run_sw = 1'b0;
    step_btn = 1'b0;
    halt_req = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #2;
    run_sw = 1'b1;
    step_btn = 1'b1;
    halt_req = 1'b1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (state !== 2'b00 || cpu_ce !== 1'b0 || cycle_count !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_async: state=%b ce=%b cnt=%0d, required 00/0/0", state, cpu_ce, cycle_count);
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      run_sw = ~run_sw;
      step_btn = ~step_btn;
      halt_req = (i % 3) == 0;
      n_checks++;
      if (state !== 2'b00 || cpu_ce !== 1'b0 || cycle_count !== 3'd0) begin
        n_fail++;
        $display("FAIL reset_hold[%0d]: state=%b ce=%b cnt=%0d, required 00/0/0", i, state, cpu_ce, cycle_count);
      end
    end
    run_sw = 1'b0;
    step_btn = 1'b0;
    halt_req = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    n_checks++;
    if (state !== 2'b00 || cpu_ce !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: state=%b ce=%b, required 00/0", state, cpu_ce);
    end
  endtask

  task automatic test_run();
    int pulses;
    logic [1:0] exp_state;
    logic exp_ce;
    logic [CW-1:0] exp_cnt;
    apply_reset();
    run_sw = 1'b1;
    pulses = 0;
    for (int n = 1; n <= 40; n++) begin
      tick();
      exp_state = (n >= 3 && n <= 32) ? 2'b01 : 2'b00;
      exp_ce = (n >= 7 && n <= 31 && ((n - 3) % 4) == 0);
      exp_cnt = (pulses > 7) ? 3'd7 : CW'(pulses);
      n_checks++;
      if (state !== exp_state) begin
        n_fail++;
        $display("FAIL run_state[%0d]: got %b, required %b", n, state, exp_state);
      end
      n_checks++;
      if (cpu_ce !== exp_ce) begin
        n_fail++;
        $display("FAIL run_ce[%0d]: got %b, required %b", n, cpu_ce, exp_ce);
      end
      n_checks++;
      if (cycle_count !== exp_cnt) begin
        n_fail++;
        $display("FAIL run_count[%0d]: got %0d, required %0d", n, cycle_count, exp_cnt);
      end
      if (exp_ce) pulses++;
      if (n == 30) run_sw = 1'b0;
    end
  endtask

  task automatic test_saturate();
    bit seen;
    run_sw = 1'b1;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (cpu_ce === 1'b1) seen = 1;
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL sat_pulse: no cpu_ce within 20 cycles, required a pulse");
    end
    tick();
    n_checks++;
    if (cycle_count !== 3'd7) begin
      n_fail++;
      $display("FAIL sat_count: got %0d, required 7", cycle_count);
    end
    run_sw = 1'b0;
  endtask

  task automatic test_step();
    logic [24:0] pat;
    int pulses;
    logic prev_ce;
    logic [1:0] prev_state;
    apply_reset();
    pat = {10'h000, 10'h3FF, 5'b01101};
    pulses = 0;
    prev_ce = 1'b0;
    prev_state = 2'b00;
    for (int k = 0; k < 60; k++) begin
      step_btn = (k < 50) ? pat[k % 25] : 1'b0;
      tick();
      n_checks++;
      if (state !== 2'b00 && state !== 2'b10) begin
        n_fail++;
        $display("FAIL step_state_range[%0d]: got %b, required 00 or 10", k, state);
      end
      n_checks++;
      if (cpu_ce !== (state == 2'b10)) begin
        n_fail++;
        $display("FAIL step_ce_state[%0d]: ce=%b state=%b, required ce high exactly in STEP", k, cpu_ce, state);
      end
      n_checks++;
      if (prev_state == 2'b10 && state !== 2'b00) begin
        n_fail++;
        $display("FAIL step_exit[%0d]: got %b after STEP, required 00", k, state);
      end
      n_checks++;
      if (prev_ce && cpu_ce) begin
        n_fail++;
        $display("FAIL step_ce_width[%0d]: ce high two cycles, required one", k);
      end
      if (cpu_ce === 1'b1) pulses++;
      prev_ce = cpu_ce;
      prev_state = state;
    end
    n_checks++;
    if (pulses != 2) begin
      n_fail++;
      $display("FAIL step_pulses: got %0d, required 2", pulses);
    end
    n_checks++;
    if (cycle_count !== 3'd2) begin
      n_fail++;
      $display("FAIL step_count: got %0d, required 2", cycle_count);
    end
  endtask

  task automatic test_halt();
    bit in_run;
    apply_reset();
    run_sw = 1'b1;
    in_run = 0;
    for (int i = 0; i < 10 && !in_run; i++) begin
      tick();
      if (state === 2'b01) in_run = 1;
    end
    n_checks++;
    if (!in_run) begin
      n_fail++;
      $display("FAIL halt_enter_run: state=%b, required 01 within 10 cycles", state);
    end
    tick();
    tick();
    tick();
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    n_checks++;
    if (cpu_ce !== 1'b0 || state !== 2'b11) begin
      n_fail++;
      $display("FAIL halt_suppress: ce=%b state=%b, required 0/11", cpu_ce, state);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if (state !== 2'b11 || cpu_ce !== 1'b0) begin
        n_fail++;
        $display("FAIL halt_hold[%0d]: state=%b ce=%b, required 11/0", i, state, cpu_ce);
      end
    end
    run_sw = 1'b0;
    tick();
    tick();
    n_checks++;
    if (state !== 2'b11) begin
      n_fail++;
      $display("FAIL halt_sync_delay: got %b, required 11", state);
    end
    tick();
    n_checks++;
    if (state !== 2'b00) begin
      n_fail++;
      $display("FAIL halt_exit: got %b, required 00", state);
    end
    n_checks++;
    if (cycle_count !== 3'd0) begin
      n_fail++;
      $display("FAIL halt_count: got %0d, required 0", cycle_count);
    end
  endtask

  task automatic test_halt_step();
    apply_reset();
    halt_req = 1'b1;
    tick();
    n_checks++;
    if (state !== 2'b11) begin
      n_fail++;
      $display("FAIL hstep_enter: got %b, required 11", state);
    end
    for (int k = 0; k < 20; k++) begin
      step_btn = (k < 12);
      tick();
      n_checks++;
      if (state !== 2'b11 || cpu_ce !== 1'b0 || cycle_count !== 3'd0) begin
        n_fail++;
        $display("FAIL hstep_ignore[%0d]: state=%b ce=%b cnt=%0d, required 11/0/0", k, state, cpu_ce, cycle_count);
      end
    end
    halt_req = 1'b0;
    tick();
    n_checks++;
    if (state !== 2'b00) begin
      n_fail++;
      $display("FAIL hstep_exit: got %b, required 00", state);
    end
    for (int k = 0; k < 6; k++) begin
      tick();
      n_checks++;
      if (state !== 2'b00 || cpu_ce !== 1'b0) begin
        n_fail++;
        $display("FAIL hstep_no_late_step[%0d]: state=%b ce=%b, required 00/0", k, state, cpu_ce);
      end
    end
  endtask

  task automatic test_reset_mid_pulse();
    bit in_run;
    apply_reset();
    run_sw = 1'b1;
    in_run = 0;
    for (int i = 0; i < 10 && !in_run; i++) begin
      tick();
      if (state === 2'b01) in_run = 1;
    end
    n_checks++;
    if (!in_run) begin
      n_fail++;
      $display("FAIL rmid_enter_run: state=%b, required 01 within 10 cycles", state);
    end
    for (int i = 0; i < 8; i++) tick();
    n_checks++;
    if (cpu_ce !== 1'b1 || cycle_count !== 3'd1) begin
      n_fail++;
      $display("FAIL rmid_due_pulse: ce=%b cnt=%0d, required 1/1", cpu_ce, cycle_count);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (cpu_ce !== 1'b0 || cycle_count !== 3'd0 || state !== 2'b00) begin
      n_fail++;
      $display("FAIL rmid_async: ce=%b cnt=%0d state=%b, required 0/0/00", cpu_ce, cycle_count, state);
    end
    tick();
    rst_n = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      n_checks++;
      if (state !== ((i == 3) ? 2'b01 : 2'b00)) begin
        n_fail++;
        $display("FAIL rmid_resample[%0d]: got %b, required %b", i, state, (i == 3) ? 2'b01 : 2'b00);
      end
    end
    run_sw = 1'b0;
  endtask

  initial begin
    test_reset();
    test_run();
    test_saturate();
    test_step();
    test_halt();
    test_halt_step();
    test_reset_mid_pulse();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
